// File: rtl/os_16bit_19_dec.sv
// os_16bit_19_dec: two-stage valid/ready decoder recovering the 7-bit payload with syndrome and error counting
module os_16bit_19_dec #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [14:0]      y,
    input  logic [7:0]       z0,
    input  logic [14:0]      z1,
    input  logic [7:0]       z2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [6:0]       o,
    output logic [7:0]       syndrome,
    output logic             err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             clr
);
    logic [14:0]      y_q, y_d, z1_q, z1_d;
    logic [7:0]       z0_q, z0_d, z2_q, z2_d;
    logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic [6:0]       o_q, o_d, oa, ob;
    logic [7:0]       syndrome_q, syndrome_d;
    logic             err_q, err_d, err_sticky_q, err_sticky_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             p, s1_adv, s2_adv, in_hs, out_hs, load_s2;

    // flow control, decode of the stage-1 word and next-state for every register
    always_comb begin
        s2_adv       = !s2_valid_q | out_ready;
        s1_adv       = !s1_valid_q | s2_adv;
        in_ready     = s1_adv;
        in_hs        = in_valid & s1_adv;
        out_hs       = s2_valid_q & out_ready;
        load_s2      = s2_adv & s1_valid_q;
        oa           = y_q[6:0] ^ z1_q[6:0] ^ z0_q[6:0];
        ob           = y_q[14:8] ^ z1_q[14:8] ^ z2_q[7:1];
        p            = y_q[7] ^ z2_q[0] ^ z1_q[7] ^ z0_q[7];
        y_d          = in_hs ? y : y_q;
        z0_d         = in_hs ? z0 : z0_q;
        z1_d         = in_hs ? z1 : z1_q;
        z2_d         = in_hs ? z2 : z2_q;
        s1_valid_d   = s1_adv ? in_valid : s1_valid_q;
        s2_valid_d   = s2_adv ? s1_valid_q : s2_valid_q;
        o_d          = load_s2 ? oa : o_q;
        syndrome_d   = load_s2 ? {p, oa ^ ob} : syndrome_q;
        err_d        = load_s2 ? |{p, oa ^ ob} : err_q;
        err_sticky_d = clr ? 1'b0 : err_sticky_q | (out_hs & err_q);
        err_cnt_d    = clr ? '0 : (out_hs & err_q & ~&err_cnt_q) ? err_cnt_q + CNT_W'(1) : err_cnt_q;
    end

    // pipeline and counter registers; reset discards in-flight words
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q          <= '0;
            z0_q         <= '0;
            z1_q         <= '0;
            z2_q         <= '0;
            s1_valid_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            o_q          <= '0;
            syndrome_q   <= '0;
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            y_q          <= y_d;
            z0_q         <= z0_d;
            z1_q         <= z1_d;
            z2_q         <= z2_d;
            s1_valid_q   <= s1_valid_d;
            s2_valid_q   <= s2_valid_d;
            o_q          <= o_d;
            syndrome_q   <= syndrome_d;
            err_q        <= err_d;
            err_sticky_q <= err_sticky_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign o          = o_q;
    assign syndrome   = syndrome_q;
    assign err        = err_q;
    assign err_sticky = err_sticky_q;
    assign err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_os_16bit_19_dec.sv
// tb_os_16bit_19_dec: directed vectors with a scoreboard queue and an independent output monitor
module tb_os_16bit_19_dec;
    localparam int CNT_W = 2;
    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0, clr = 1'b0;
    logic [14:0] y = '0, z1 = '0;
    logic [7:0] z0 = '0, z2 = '0;
    logic in_ready, out_valid, err, err_sticky;
    logic [6:0] o;
    logic [7:0] syndrome;
    logic [CNT_W-1:0] err_cnt;
    int n_vec = 0, n_bad = 0;
    logic [15:0] sb[$];
    logic [15:0] exp_w, hold_val;
    logic hold_v = 1'b0, e;
    logic [CNT_W-1:0] m_cnt = '0;
    logic m_st = 1'b0;

    os_16bit_19_dec #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .y(y), .z0(z0), .z1(z1), .z2(z2), .out_valid(out_valid), .out_ready(out_ready),
        .o(o), .syndrome(syndrome), .err(err), .err_sticky(err_sticky),
        .err_cnt(err_cnt), .clr(clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // present a word and hold it until accepted; expected result goes to the scoreboard
    task automatic send(input logic [14:0] yy, input logic [7:0] a, input logic [14:0] b,
                        input logic [7:0] c, input logic [6:0] eo, input logic [7:0] es);
        bit ok = 0;
        @(posedge clk); #1;
        y = yy; z0 = a; z1 = b; z2 = c; in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back({eo, es, |es});
                ok = 1;
            end
        end
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        chk("drain", sb.size(), 0);
    endtask

    // monitor: compare each output handshake against the scoreboard and track the counter model
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            m_cnt = '0;
            m_st = 1'b0;
            hold_v = 1'b0;
        end else begin
            e = 1'b0;
            chk("err_cnt", err_cnt, m_cnt);
            chk("err_sticky", err_sticky, m_st);
            if (out_valid && hold_v) chk("stall_hold", {o, syndrome, err}, hold_val);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_output: got o=0x%0h required none", o);
                end else begin
                    exp_w = sb.pop_front();
                    chk("o", o, exp_w[15:9]);
                    chk("syndrome", syndrome, exp_w[8:1]);
                    chk("err", err, exp_w[0]);
                    e = exp_w[0];
                end
            end
            hold_v = out_valid & !out_ready;
            hold_val = {o, syndrome, err};
            if (clr) begin
                m_cnt = '0;
                m_st = 1'b0;
            end else if (e) begin
                m_st = 1'b1;
                if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
            end
        end
    end

    initial begin
        bit seen;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_o", o, 0);
        chk("rst_syndrome", syndrome, 0);
        chk("rst_err", err, 0);
        chk("rst_err_sticky", err_sticky, 0);
        chk("rst_err_cnt", err_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        // clean word with latency check
        send(15'h5555, 8'h00, 15'h0000, 8'h00, 7'h55, 8'h00);
        idle();
        @(negedge clk);
        chk("lat_n", out_valid, 0);
        @(negedge clk);
        chk("lat_n1", out_valid, 1);
        chk("lat_o", o, 7'h55);
        drain();
        chk("clean_cnt", err_cnt, 0);
        // nonzero side words
        send(15'h2AAA, 8'hFF, 15'h7FFF, 8'hFF, 7'h2A, 8'h00);
        idle();
        drain();
        // single-bit faults
        send(15'h5554, 8'h00, 15'h0000, 8'h00, 7'h54, 8'h01);
        idle();
        drain();
        chk("fault1_cnt", err_cnt, 1);
        send(15'h55D5, 8'h00, 15'h0000, 8'h00, 7'h55, 8'h80);
        idle();
        drain();
        chk("fault2_sticky", err_sticky, 1);
        chk("fault2_cnt", err_cnt, 2);
        // backpressure: two words fill the pipe, then stall for 3 cycles
        out_ready = 1'b0;
        send(15'h0101, 8'h00, 15'h0000, 8'h00, 7'h01, 8'h00);
        send(15'h0202, 8'h00, 15'h0000, 8'h00, 7'h02, 8'h00);
        idle();
        @(negedge clk);
        chk("bp_in_ready", in_ready, 0);
        fork
            begin
                send(15'h0303, 8'h00, 15'h0000, 8'h00, 7'h03, 8'h00);
                send(15'h0404, 8'h00, 15'h0000, 8'h00, 7'h04, 8'h00);
                idle();
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_cnt", err_cnt, 2);
        // standalone clear
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        @(negedge clk);
        chk("clr_cnt", err_cnt, 0);
        chk("clr_sticky", err_sticky, 0);
        // saturation with 5 back-to-back erroneous words
        for (int k = 0; k < 5; k++) send(15'h5554, 8'h00, 15'h0000, 8'h00, 7'h54, 8'h01);
        idle();
        drain();
        chk("sat_cnt", err_cnt, 3);
        chk("sat_sticky", err_sticky, 1);
        // clear coinciding with a 6th erroneous handshake
        out_ready = 1'b0;
        send(15'h5554, 8'h00, 15'h0000, 8'h00, 7'h54, 8'h01);
        idle();
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        if (!seen) chk("clr_hs_timeout", 0, 1);
        @(posedge clk); #1;
        clr = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        @(negedge clk);
        chk("clrhs_cnt", err_cnt, 0);
        chk("clrhs_sticky", err_sticky, 0);
        drain();
        // reset with both stages full
        send(15'h5554, 8'h00, 15'h0000, 8'h00, 7'h54, 8'h01);
        idle();
        drain();
        chk("pre_rst_cnt", err_cnt, 1);
        out_ready = 1'b0;
        send(15'h5554, 8'h00, 15'h0000, 8'h00, 7'h54, 8'h01);
        send(15'h0505, 8'h00, 15'h0000, 8'h00, 7'h05, 8'h00);
        idle();
        @(negedge clk);
        chk("full_out_valid", out_valid, 1);
        chk("full_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", out_valid, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_cnt", err_cnt, 0);
        repeat (5) @(negedge clk);
        chk("post_rst_out_valid", out_valid, 0);
        chk("final_queue", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/os_16bit_19_dec.md
Name: os_16bit_19_dec

Overview:
- Receive-side decoder for the 15-bit os_16bit_19 mixed word.
- Takes the mixed word y plus the side words z0, z1, z2 and recovers the 7-bit payload o.
- Uses the redundant copy of o (y[14:8]) and the y[7] parity bit to form an 8-bit syndrome, an error flag and a saturating error count.
- Sits in the streaming datapath behind the link, with valid/ready handshakes, a 2-stage pipeline and full throughput.

Parameters:
- CNT_W, 16, width of the saturating error counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  decoder can accept an input word.
- y  input  15  mixed word.
- z0  input  8  side word 0.
- z1  input  15  side word 1.
- z2  input  8  side word 2.
- out_valid  output  1  decoded result valid.
- out_ready  input  1  downstream accepts the result.
- o  output  7  recovered payload.
- syndrome  output  8  {parity bit, 7-bit copy mismatch}.
- err  output  1  syndrome != 0 for the current output.
- err_sticky  output  1  set by any accepted erroneous result.
- err_cnt  output  CNT_W  number of accepted erroneous results, saturating.
- clr  input  1  synchronous clear of err_sticky and err_cnt.

Behaviour:
- Decode equations, for i = 0..6:
  - oa[i] = y[i] ^ z1[i] ^ z0[i]
  - ob[i] = y[8+i] ^ z1[8+i] ^ z2[1+i]
  - p = y[7] ^ z2[0] ^ z1[7] ^ z0[7]
  - o = oa; syndrome = {p, oa ^ ob}; err = |syndrome.
- Pipeline:
  - Stage 1 registers y, z0, z1, z2 and s1_valid on an input handshake (in_valid & in_ready).
  - Stage 2 registers o, syndrome, err and s2_valid from stage 1.
  - out_valid = s2_valid.
  - Latency is 2 cycles: a word accepted at edge N appears on the outputs after edge N+1 when there is no stall.
- Flow control:
  - s2 advances when !s2_valid | out_ready.
  - s1 advances when !s1_valid | s2 advances.
  - in_ready = !s1_valid | s2 advances. This is combinational from out_ready, with no registered skid.
  - One word per cycle is sustained when out_ready is held high.
  - While out_valid & !out_ready, o, syndrome and err hold stable and no data is lost or duplicated.
  - When a stage is not loaded, its valid clears; data registers may hold stale values.
- Counters:
  - On each output handshake (out_valid & out_ready) with err = 1: err_cnt increments and err_sticky sets.
  - err_cnt saturates at 2^CNT_W - 1 and does not wrap.
  - clr has priority over a same-cycle increment: err_cnt becomes 0 and err_sticky becomes 0, and that cycle's error is not counted.
  - clr does not affect pipeline contents.
- Reset (async assert, sync release): s1_valid = s2_valid = 0, out_valid = 0, o = 0, syndrome = 0, err = 0, err_sticky = 0, err_cnt = 0. in_ready = 1 in the first cycle after reset release.
- Reset asserted mid-transfer discards all in-flight words; no output handshake occurs for them.
- An error-free word always gives syndrome = 0x00. This is the exact inverse of the os_16bit_19 encoder when z0, z1, z2 match the encoder side.

Test Plan:
- Clean word:
  - Stimulus: z0 = 0x00, z1 = 0x0000, z2 = 0x00, y = 0x5555, out_ready = 1.
  - Required: o = 0x55, syndrome = 0x00, err = 0, 2 cycles after the handshake; err_cnt stays 0.
- Side words nonzero:
  - Stimulus: z0 = 0xFF, z1 = 0x7FFF, z2 = 0xFF, y = encoder(o = 0x2A) = 0x2AAA.
  - Required: o = 0x2A, syndrome = 0x00.
- Single-bit faults on the clean word:
  - y = 0x5554 -> o = 0x54, syndrome = 0x01, err = 1, err_cnt = 1.
  - y = 0x55D5 -> o = 0x55, syndrome = 0x80, err = 1, err_sticky = 1.
- Backpressure:
  - Stimulus: stream 4 clean words with o = 0x01..0x04; hold out_ready = 0 for 3 cycles, then release.
  - Required: in_ready drops after 2 words are buffered; all 4 outputs appear in order with none lost or duplicated; o is stable while stalled.
- Saturation and clear:
  - Stimulus: CNT_W = 2, send 5 erroneous words.
  - Required: err_cnt = 3.
  - Stimulus: assert clr in the same cycle as a 6th erroneous handshake.
  - Required: err_cnt = 0, err_sticky = 0.
- Reset mid-stream:
  - Stimulus: assert rst_n = 0 with both stages valid.
  - Required: out_valid = 0 immediately (asynchronously); after release, in_ready = 1 and err_cnt = 0.
